// File: rtl/vespa_pkg.sv
// Shared VeSPA pipeline definitions: opcodes, instruction size and the
// encoding of the fetch-stage controller.
package vespa_pkg;

    localparam logic [4:0]  OPC_NOP     = 5'd0;
    localparam logic [4:0]  OPC_HLT     = 5'd31;
    localparam logic [31:0] NOP_WORD    = {OPC_NOP, 27'd0};
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] word);
        return word[31:27];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its next-PC while the
// decode stage is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] word_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] word,
    output logic [31:0] pc
);

    logic        valid_q, valid_d;
    logic [31:0] word_q, word_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        valid_d = valid_q;
        word_d  = word_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            word_d  = word_in;
            pc_d    = pc_in;
        end
    end

    // NOTE: the payload is reset along with valid so a stale word can never surface after clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign word  = word_q;
    assign pc    = pc_q;

endmodule

// File: rtl/stage1_fetch.sv
// VeSPA instruction-fetch stage: drives the req/ack instruction memory port and
// feeds IR2/PC2 to decode, honouring stalls, redirects and HLT.
module stage1_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4,
    parameter logic [4:0]  HLT_OPC  = 5'd31
) (
    input  logic        clk,
    input  logic        clr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        pause2,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IR2,
    output logic [31:0] PC2,
    output logic        halted
);
    import vespa_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir2_q, ir2_d;
    logic [31:0]  pc2_q, pc2_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         req_en_q, req_en_d;

    logic         buf_load, buf_clear, buf_valid;
    logic [31:0]  buf_word, buf_pc;
    logic         mem_req, mem_take;
    logic [31:0]  pc_next;

    // req_en_q keeps the port idle for the first cycle after clr releases.
    assign mem_req  = req_en_q && (state_q == FETCH || state_q == DRAIN);
    assign mem_take = mem_req && imem_ack;
    assign pc_next  = pc_q + PC_INC;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (clr),
        .load    (buf_load),
        .clear   (buf_clear),
        .word_in (imem_data),
        .pc_in   (pc_next),
        .valid   (buf_valid),
        .word    (buf_word),
        .pc      (buf_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir2_d        = ir2_q;
        pc2_d        = pc2_q;
        drain_addr_d = drain_addr_q;
        req_en_d     = 1'b1;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        if (redirect) begin
            ir2_d     = NOP_WORD;
            pc2_d     = 32'h0;
            buf_clear = 1'b1;
            pc_d      = redirect_pc;
            if (mem_req && !imem_ack) begin
                // The outstanding address must stay on the bus until acked.
                state_d = DRAIN;
                if (state_q != DRAIN) drain_addr_d = pc_q;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (mem_take) begin
                        pc_d = pc_next;
                        if (!pause2) begin
                            ir2_d   = imem_data;
                            pc2_d   = pc_next;
                            state_d = (opcode_of(imem_data) == HLT_OPC) ? HALT : FETCH;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end else if (!pause2) begin
                        ir2_d = NOP_WORD;
                    end
                end
                HOLD: begin
                    if (!pause2 && buf_valid) begin
                        ir2_d     = buf_word;
                        pc2_d     = buf_pc;
                        buf_clear = 1'b1;
                        state_d   = (opcode_of(buf_word) == HLT_OPC) ? HALT : FETCH;
                    end
                end
                DRAIN: begin
                    if (mem_take) state_d = FETCH;
                end
                HALT: begin
                    if (!pause2) ir2_d = NOP_WORD;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ir2_q        <= NOP_WORD;
            pc2_q        <= 32'h0;
            drain_addr_q <= RESET_PC;
            req_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir2_q        <= ir2_d;
            pc2_q        <= pc2_d;
            drain_addr_q <= drain_addr_d;
            req_en_q     <= req_en_d;
        end
    end

    assign imem_req  = mem_req;
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign IR2       = ir2_q;
    assign PC2       = pc2_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_stage1_fetch.sv
// Directed bench for stage1_fetch with a program-order issue model and a
// variable-latency instruction memory responder.
module tb_stage1_fetch;

    logic        clk;
    logic        clr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        pause2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IR2;
    logic [31:0] PC2;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int wait_cnt;

    stage1_fetch dut (
        .clk         (clk),
        .clr         (clr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .pause2      (pause2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IR2         (IR2),
        .PC2         (PC2),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: a few fixed words, HLT at 0x108 and 0x48, opcode 3 elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0800_0001;
            32'h0000_0004: return 32'h1000_0002;
            32'h0000_000C: return 32'h1800_0000;
            32'h0000_0048: return 32'hF800_0000;
            32'h0000_0108: return 32'hF800_0000;
            default:       return {5'd3, a[28:2]};
        endcase
    endfunction

    // Memory responder: ack after 'lat' extra wait cycles of a held request.
    always @(posedge clk or negedge clr) begin
        if (!clr)                               wait_cnt <= 0;
        else if (!imem_req || imem_ack)         wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack  = imem_req && (wait_cnt >= lat);
    assign imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Issue model: every non-bubble IR2 accepted by decode must be the next
    // word in program order from the last reset/redirect target.
    logic        p_clr, p_pause, p_redir, p_req, p_ack;
    logic [31:0] p_rpc, p_addr;
    logic [31:0] exp_pc   = 32'h0;
    logic        halted_m = 1'b0;
    logic [31:0] prev_ir2 = 32'h0;
    logic [31:0] prev_pc2 = 32'h0;
    logic [31:0] w;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            p_clr   = clr;
            p_pause = pause2;
            p_redir = redirect;
            p_rpc   = redirect_pc;
            p_req   = imem_req;
            p_ack   = imem_ack;
            p_addr  = imem_addr;
            @(posedge clk);
            #1;
            if (!p_clr) begin
                exp_pc   = 32'h0;
                halted_m = 1'b0;
                check("mon_rst_ir2", IR2, 32'h0);
                check("mon_rst_pc2", PC2, 32'h0);
                check("mon_rst_req", {31'd0, imem_req}, 32'd0);
                check("mon_rst_halted", {31'd0, halted}, 32'd0);
            end else begin
                if (p_req && !p_ack) begin
                    check("mon_req_held", {31'd0, imem_req}, 32'd1);
                    check("mon_addr_stable", imem_addr, p_addr);
                end
                if (p_redir) begin
                    exp_pc   = p_rpc;
                    halted_m = 1'b0;
                    check("mon_redir_ir2", IR2, 32'h0);
                    check("mon_redir_pc2", PC2, 32'h0);
                end else if (p_pause) begin
                    check("mon_pause_ir2", IR2, prev_ir2);
                    check("mon_pause_pc2", PC2, prev_pc2);
                end else if (halted_m) begin
                    check("mon_halt_ir2", IR2, 32'h0);
                end else if (IR2 != 32'h0) begin
                    w = mem_word(exp_pc);
                    check("mon_issue_ir2", IR2, w);
                    check("mon_issue_pc2", PC2, exp_pc + 32'd4);
                    if (w[31:27] == 5'd31) halted_m = 1'b1;
                    exp_pc = exp_pc + 32'd4;
                end
                check("mon_halted", {31'd0, halted}, {31'd0, halted_m});
            end
            prev_ir2 = IR2;
            prev_pc2 = PC2;
        end
    end

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clr = 1'b1; pause2 = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #2 clr = 1'b0;
        nxt(2);
        check("rst_ir2", IR2, 32'h0);
        check("rst_pc2", PC2, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // Zero-wait memory: one instruction per cycle.
        clr = 1'b1;
        nxt(1);
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        nxt(1);
        check("t1_ir2_a", IR2, 32'h0800_0001);
        check("t1_pc2_a", PC2, 32'h4);
        check("t1_addr4", imem_addr, 32'h4);
        nxt(1);
        check("t1_ir2_b", IR2, 32'h1000_0002);
        check("t1_pc2_b", PC2, 32'h8);
        check("t1_addr8", imem_addr, 32'h8);

        // Two wait states: address held three cycles, two bubbles.
        lat = 2;
        nxt(1);
        check("t2_bubble1", IR2, 32'h0);
        check("t2_addr_h1", imem_addr, 32'h8);
        nxt(1);
        check("t2_bubble2", IR2, 32'h0);
        check("t2_addr_h2", imem_addr, 32'h8);
        nxt(1);
        check("t2_ir2", IR2, 32'h1800_0002);
        check("t2_pc2", PC2, 32'hC);
        check("t2_addr_c", imem_addr, 32'hC);

        // Stall lands on the ack cycle of 0xC: word parked in the skid buffer.
        nxt(2);
        pause2 = 1'b1;
        nxt(1);
        check("t3_req_hold1", {31'd0, imem_req}, 32'd0);
        check("t3_ir2_frz1", IR2, 32'h0);
        check("t3_pc2_frz1", PC2, 32'hC);
        nxt(1);
        check("t3_req_hold2", {31'd0, imem_req}, 32'd0);
        check("t3_pc2_frz2", PC2, 32'hC);
        pause2 = 1'b0;
        nxt(1);
        check("t3_ir2_pop", IR2, 32'h1800_0000);
        check("t3_pc2_pop", PC2, 32'h10);
        check("t3_addr_10", imem_addr, 32'h10);

        // Redirect while the request to 0x20 is waiting.
        lat = 0;
        nxt(4);
        check("t4_addr_20", imem_addr, 32'h20);
        lat = 3; redirect = 1'b1; redirect_pc = 32'h100;
        nxt(1);
        redirect = 1'b0;
        check("t4_ir2_flush", IR2, 32'h0);
        check("t4_pc2_flush", PC2, 32'h0);
        check("t4_drain_req", {31'd0, imem_req}, 32'd1);
        check("t4_drain_addr", imem_addr, 32'h20);
        nxt(1);
        check("t4_drain_addr2", imem_addr, 32'h20);
        check("t4_drain_ir2", IR2, 32'h0);
        nxt(2);
        check("t4_new_addr", imem_addr, 32'h100);
        check("t4_discard", IR2, 32'h0);
        lat = 0;
        nxt(1);
        check("t4_ir2_100", IR2, 32'h1800_0040);
        check("t4_pc2_100", PC2, 32'h104);

        // HLT at 0x108.
        nxt(2);
        check("t5_hlt_ir2", IR2, 32'hF800_0000);
        check("t5_hlt_pc2", PC2, 32'h10C);
        check("t5_halted", {31'd0, halted}, 32'd1);
        nxt(1);
        check("t5_after_ir2", IR2, 32'h0);
        check("t5_after_req", {31'd0, imem_req}, 32'd0);
        pause2 = 1'b1;
        nxt(1);
        pause2 = 1'b0;
        nxt(1);
        check("t5_still_halted", {31'd0, halted}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        nxt(1);
        redirect = 1'b0;
        check("t5_unhalt", {31'd0, halted}, 32'd0);
        check("t5_resume_addr", imem_addr, 32'h40);
        nxt(1);
        check("t5_ir2_40", IR2, 32'h1800_0010);
        check("t5_pc2_40", PC2, 32'h44);

        // Redirect in the same cycle a HLT word is acked: redirect wins.
        nxt(1);
        check("t5b_addr_48", imem_addr, 32'h48);
        redirect = 1'b1; redirect_pc = 32'h200;
        nxt(1);
        redirect = 1'b0;
        check("t5b_ir2", IR2, 32'h0);
        check("t5b_halted", {31'd0, halted}, 32'd0);
        check("t5b_addr_200", imem_addr, 32'h200);
        nxt(1);
        check("t5b_ir2_200", IR2, 32'h1800_0080);

        // clr while draining an unacked request.
        lat = 3; redirect = 1'b1; redirect_pc = 32'h300;
        nxt(1);
        redirect = 1'b0;
        check("t6_drain_addr", imem_addr, 32'h204);
        nxt(1);
        clr = 1'b0;
        #1;
        check("t6_ir2", IR2, 32'h0);
        check("t6_pc2", PC2, 32'h0);
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_halted", {31'd0, halted}, 32'd0);
        lat = 0;
        nxt(2);
        clr = 1'b1;
        nxt(1);
        check("t6_restart_addr", imem_addr, 32'h0);
        check("t6_restart_req", {31'd0, imem_req}, 32'd1);
        nxt(1);
        check("t6_restart_ir2", IR2, 32'h0800_0001);
        check("t6_restart_pc2", PC2, 32'h4);

        // PC wraps modulo 2^32.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        nxt(1);
        redirect = 1'b0;
        nxt(1);
        check("t7_wrap_ir2", IR2, 32'h1FFF_FFFF);
        check("t7_wrap_pc2", PC2, 32'h0);
        check("t7_wrap_addr", imem_addr, 32'h0);
        nxt(1);
        check("t7_after_ir2", IR2, 32'h0800_0001);
        check("t7_after_pc2", PC2, 32'h4);
        nxt(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage1_fetch.md
Name: stage1_fetch

Overview:
Instruction-fetch stage of the VeSPA pipeline. It produces IR2/PC2 for the decode stage and drives a variable-latency instruction-memory request/acknowledge interface. It also honours decode-stage stalls (pause2) and later-stage control-flow redirects (taken branch/jump), and stops fetching after a HLT.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_INC, 4, byte increment between sequential instructions
HLT_OPC, 5'd31, opcode value (IR[31:27]) that halts fetch

Ports:
clk  in  1  pipeline clock, rising edge
clr  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction read request, level
imem_addr  out  32  fetch address, valid while imem_req=1
imem_ack  in  1  data valid this cycle; may assert in the same cycle as imem_req
imem_data  in  32  instruction word, sampled only when imem_req & imem_ack
pause2  in  1  decode stage stalled; hold IR2/PC2
redirect  in  1  taken branch/jump resolved downstream
redirect_pc  in  32  new fetch address, valid with redirect
IR2  out  32  instruction to decode stage; NOP = 32'h0
PC2  out  32  address of IR2 instruction + PC_INC
halted  out  1  fetch stopped on HLT

Behaviour:
- Reset (clr=0, asynchronous): PC=RESET_PC, IR2=0, PC2=0, halted=0, buffer empty, state=FETCH, imem_req=0 while clr low.
- Memory rule: once imem_req rises, imem_addr stays stable and imem_req stays high until a cycle with imem_ack=1. Requests are never abandoned.
- States: FETCH, HOLD, DRAIN, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Ack with pause2=0: IR2<=imem_data, PC2<=PC+PC_INC, PC<=PC+PC_INC.
    - If imem_data[31:27]==HLT_OPC, go to HALT. Otherwise stay in FETCH, with a back-to-back request next cycle.
  - Ack with pause2=1: store word and PC+PC_INC in a 1-entry buffer, PC<=PC+PC_INC, go to HOLD. IR2/PC2 hold.
  - No ack: IR2<=0 (bubble) if pause2=0, else hold.
- HOLD:
  - imem_req=0; IR2/PC2 hold while pause2=1.
  - When pause2=0: IR2/PC2 load from the buffer, buffer empties.
    - Next state is HALT if the buffered opcode is HLT_OPC, else FETCH.
- HALT:
  - imem_req=0, halted=1, IR2<=0 when pause2=0 (HLT itself already issued). PC holds.
- Redirect (highest priority, any state, overrides pause2):
  - IR2<=0, PC2<=0, buffer cleared, halted<=0, PC<=redirect_pc.
  - If a request is outstanding and imem_ack=0 this cycle, go to DRAIN. Otherwise go to FETCH; any word acked that cycle is discarded.
- DRAIN:
  - imem_req=1 with the old address until ack; data is discarded, IR2 stays 0. Then go to FETCH at PC.
  - A second redirect in DRAIN overwrites PC and stays in DRAIN.
- Arithmetic: PC+PC_INC wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 0). No misalignment checks.
- Latency: zero-wait memory gives one instruction per cycle, and IR2 updates on the edge ending the ack cycle. First IR2 after reset is available at the second rising edge after clr release.
- Simultaneous redirect and HLT ack: redirect wins, HLT is discarded, halted stays 0.

Decomposition:
- Shared package (vespa_pkg): OPC_NOP=5'd0, OPC_HLT=5'd31, NOP_WORD=32'h0, PC_INC constant, fetch state encoding (FETCH/HOLD/DRAIN/HALT).
- No sub-module required. The 1-entry skid buffer (word + PC) may be split out as fetch_skid_buf if reused by a future prefetch queue.

Test Plan:
1. Reset, zero-wait memory returning 0x08000001, 0x10000002 at 0x0, 0x4 -> IR2 sequence 0x08000001, 0x10000002; PC2 = 0x4, 0x8; imem_addr 0x0, 0x4, 0x8 on consecutive cycles.
2. 3-cycle ack latency -> imem_addr held stable for 3 cycles; two bubbles (IR2=0) inserted; PC2 increments by 4 per accepted word.
3. pause2 high for 2 cycles while ack arrives with word 0x18000000 -> IR2/PC2 frozen, imem_req=0 in HOLD; word appears on IR2 the edge after pause2 falls; no word lost or duplicated.
4. redirect=1, redirect_pc=0x100 while a request to 0x20 is outstanding -> IR2=0, imem_req stays high at 0x20 until ack, that data discarded, then imem_addr=0x100.
5. Fetch 0xF8000000 (HLT) -> IR2=0xF8000000 once, then zeros, halted=1, imem_req=0. Later redirect to 0x40 -> halted=0, fetch resumes at 0x40.
6. clr pulsed low mid-DRAIN with ack pending -> immediate IR2=0, PC2=0, imem_req=0, halted=0; after release fetch restarts at RESET_PC.
